// File: rtl/soma_serial_ctrl_pkg.sv
// soma_pkg: shared definitions for the bit-serial adder controller.
//   state_e  - controller FSM encoding (IDLE / RUN / DONE)
//   cnt_w()  - bit-step counter width for a given operand width
package soma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter must still exist as one bit when N=1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/soma_serial_ctrl_if.sv
// soma_serial_ctrl_if: request/result bundle between a datapath and the
// bit-serial adder controller.
//   start, a, b, cin : request side, driven by the master
//   busy, done       : status, driven by the controller (slave)
//   sum, cout        : result, driven by the controller, held until next completion
interface soma_serial_ctrl_if #(parameter int N = 8);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         cout;

  modport master (output start, a, b, cin, input  busy, done, sum, cout);
  modport slave  (input  start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/soma_serial_ctrl_full.sv
// soma1bit_half: combinational 1-bit half adder.
//   a_i, b_i -> sum_o (a^b), carry_o (a&b)
// soma1bit_full: combinational 1-bit full adder from two half adders + OR.
//   a_i, b_i, cin_i -> sum_o, carry_o
module soma1bit_half (
  input  logic a_i,
  input  logic b_i,
  output logic sum_o,
  output logic carry_o
);
  assign sum_o   = a_i ^ b_i;
  assign carry_o = a_i & b_i;
endmodule

module soma1bit_full (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic carry_o
);
  logic s0, c0, c1;

  soma1bit_half u_ha0 (.a_i(a_i), .b_i(b_i),   .sum_o(s0),    .carry_o(c0));
  soma1bit_half u_ha1 (.a_i(s0),  .b_i(cin_i), .sum_o(sum_o), .carry_o(c1));

  // Both half-adder carries can never be high together, so OR is exact.
  assign carry_o = c0 | c1;
endmodule

// File: rtl/soma_serial_ctrl.sv
// soma_serial_ctrl: bit-serial N-bit adder controller. One full-adder cell
// is stepped over N cycles LSB first, the carry living in a register.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - slave side of soma_serial_ctrl_if:
//           start/a/b/cin in (sampled in IDLE or DONE only),
//           busy (RUN), done (1-cycle pulse), sum/cout (held result)
// Latency: start accepted at edge k -> sum/cout written at edge k+N,
// done high during the following cycle.
module soma_serial_ctrl
  import soma_pkg::*;
#(
  parameter int N = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  soma_serial_ctrl_if.slave bus
);

  localparam int CW = cnt_w(N);

  state_e          state_q, state_d;
  logic [N-1:0]    sha_q, sha_d;
  logic [N-1:0]    shb_q, shb_d;
  logic [N-1:0]    acc_q, acc_d;
  logic [N-1:0]    sum_q, sum_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            fa_s, fa_c;
  logic [N-1:0]    acc_shift;
  logic            last;
  logic            accept;
  logic            busy, done;

  soma1bit_full u_fa (
    .a_i    (sha_q[0]),
    .b_i    (shb_q[0]),
    .cin_i  (carry_q),
    .sum_o  (fa_s),
    .carry_o(fa_c)
  );

  // New sum bit enters at the MSB; after N steps bit 0 holds the LSB.
  generate
    if (N == 1) begin : g_acc1
      assign acc_shift = fa_s;
    end else begin : g_accn
      assign acc_shift = {fa_s, acc_q[N-1:1]};
    end
  endgenerate

  assign last   = (cnt_q == CW'(N - 1));
  assign accept = bus.start && (state_q != RUN);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = bus.start ? RUN : IDLE;
      RUN:     state_d = last ? DONE : RUN;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

  // ---------------- datapath next state ----------------
  always_comb begin
    sha_d   = sha_q;
    shb_d   = shb_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    if (accept) begin
      sha_d   = bus.a;
      shb_d   = bus.b;
      carry_d = bus.cin;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      sha_d   = sha_q >> 1;
      shb_d   = shb_q >> 1;
      carry_d = fa_c;
      acc_d   = acc_shift;
      cnt_d   = last ? '0 : cnt_q + CW'(1);
      // Result registers only move on the final step: no partial sums visible.
      if (last) begin
        sum_d  = acc_shift;
        cout_d = fa_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sha_q   <= '0;
      shb_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: doc/soma_serial_ctrl.md
Name: soma_serial_ctrl

Overview:
- Bit-serial N-bit adder controller: sequences one 1-bit full-adder cell over N clock cycles, LSB first.
- Holds the running carry in a register between bit steps.
- Start/done handshake so a larger datapath can request multi-bit sums from a single 1-bit adder resource.
- Sits between operand registers and the 1-bit adder cell; trades latency for area.

Parameters:
- N, 8, operand/result width in bits; legal range N >= 1.

Ports:
- clk    input   1  rising-edge clock
- rst_n  input   1  asynchronous active-low reset
- start  input   1  request; sampled only in IDLE or DONE
- a      input   N  operand A; captured on the accepted start edge
- b      input   N  operand B; captured on the accepted start edge
- cin    input   1  carry-in; captured on the accepted start edge
- busy   output  1  high while in RUN
- done   output  1  one-cycle pulse; result valid
- sum    output  N  result; held until the next completion
- cout   output  1  final carry-out; held with sum

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst_n low asynchronously forces state=IDLE, busy=0, done=0, sum=0, cout=0, and clears internal shift registers, carry and counter.
  - Reset mid-RUN aborts the operation; no done pulse is issued.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - start=1 at an edge: load shift_a<=a, shift_b<=b, carry<=cin, cnt<=0, then go to RUN.
- RUN:
  - busy=1.
  - Each edge computes {c,s} = shift_a[0] + shift_b[0] + carry through the full-adder cell.
  - Register updates on that edge: carry<=c; shift_acc<={s, shift_acc[N-1:1]}; shift_a and shift_b shift right by 1; cnt<=cnt+1.
  - On the edge where cnt==N-1: go to DONE, and load sum<={s, shift_acc[N-1:1]} and cout<=c in the same edge.
- DONE:
  - busy=0, done=1 for exactly this one cycle.
  - Next state is RUN if start=1 (new operands loaded as in IDLE); otherwise IDLE.
- Latency:
  - Start accepted at edge k.
  - done is high in the cycle following edge k+N.
  - sum and cout are updated at edge k+N.
  - Throughput is one add per N+1 cycles when start is held high.
- start while busy is ignored: no re-load, no queueing.
- sum and cout never show partial results; they change only on the edge entering DONE, or on reset.
- Operands may change after the accepted start edge with no effect on the current operation.
- Width rules:
  - cnt is max(1,$clog2(N)) bits and counts 0..N-1.
  - N=1: RUN lasts one cycle, cnt stays 0.
  - The result is the exact (N+1)-bit sum {cout,sum} = a+b+cin, modulo nothing.

Decomposition:
- Shared package/header (soma_pkg): FSM state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- Natural sub-module: soma1bit_full, a combinational 1-bit full adder (a, b, cin -> sum, carry) built from two 1-bit half-adder cells plus an OR.
- The controller instantiates exactly one soma1bit_full.

Test Plan:
- N=8, a=0x3C, b=0x0F, cin=0, start pulse at edge k -> busy high for 8 cycles; done at the cycle after edge k+8; sum=0x4B, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Mid-RUN: raise start with a=0x11, b=0x22 -> ignored; result still that of the original operands (0x3C+0x0F -> 0x4B); done pulses once.
- start held high through DONE with a=0x80, b=0x80 -> RUN re-entered with no IDLE cycle; next done 9 cycles after the previous done; sum=0x00, cout=1; prior sum held until then.
- rst_n low at RUN cycle 4 -> busy, done, sum and cout go to 0 immediately, without waiting for a clock edge; after release, state is IDLE with no done pulse.
- N=1 instance: a=1, b=1, cin=1 -> done one cycle after the RUN edge; sum=1, cout=1.
